// File: rtl/packet_framing_checker.sv
// Ingress framing sanitiser for a 32-bit word stream.
// Packets are forced to end in exactly one eop word, whether the input sent one or not.
// Packets that are too short, too long, unterminated or flagged bad upstream leave with
// obad set on their eop word. A one-word hold register lets a missing eop be patched onto
// the last word of the old packet when the next sop arrives.
module packet_framing_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int MIN_BYTES  = 64,
  parameter int MAX_BYTES  = 9600,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  ivalid,
  input  logic                  isop,
  input  logic                  ieop,
  input  logic [1:0]            iresidual,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  ibad,
  output logic                  ovalid,
  output logic                  osop,
  output logic                  oeop,
  output logic [1:0]            oresidual,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  obad,
  output logic [CNT_WIDTH-1:0]  opkt_cnt,
  output logic [CNT_WIDTH-1:0]  orphan_cnt,
  output logic [CNT_WIDTH-1:0]  trunc_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_PKT, S_DROP} state_t;

  localparam logic [14:0] MAX_LEN = 15'(MAX_BYTES);
  localparam logic [14:0] MIN_LEN = 15'(MIN_BYTES);

  state_t                state;
  logic                  hold_valid;
  logic                  hold_sop;
  logic                  hold_eop;
  logic [1:0]            hold_res;
  logic                  hold_bad;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [13:0]           len_q;
  logic                  bad_q;

  logic                  emit;
  logic                  force_term;
  logic                  accept;
  logic                  orphan_inc;
  logic                  pkt_inc;
  logic [1:0]            trunc_inc;
  logic [14:0]           base_len;
  logic [14:0]           add_len;
  logic [14:0]           new_len;
  logic                  bad_acc;
  logic                  over;
  logic                  cap_eop;
  logic [1:0]            cap_res;
  logic                  cap_bad;
  state_t                next_state;

  // Saturating add so the statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic [1:0] inc);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, cnt} + {{(CNT_WIDTH-1){1'b0}}, inc};
    return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
  endfunction

  // Decode what happens to the held word and to the incoming word this cycle.
  always_comb begin
    emit       = hold_valid & (ivalid | hold_eop);
    force_term = emit & (state == S_PKT) & ivalid & isop & ~hold_eop;
    accept     = ivalid & (isop | (state == S_PKT));
    orphan_inc = ivalid & ~isop & (state == S_IDLE);
    pkt_inc    = emit & (hold_eop | force_term);

    base_len = isop ? 15'd0 : {1'b0, len_q};
    add_len  = 15'd4;
    if (ieop && (iresidual != 2'd0)) begin
      add_len = {13'd0, iresidual};
    end
    new_len = base_len + add_len;
    bad_acc = (isop ? 1'b0 : bad_q) | ibad;

    // A non-eop word that reaches the limit leaves no room for any further byte.
    over    = ieop ? (new_len > MAX_LEN) : (new_len >= MAX_LEN);
    cap_eop = ieop | over;
    cap_res = (ieop & ~over) ? iresidual : 2'd0;
    cap_bad = over | (ieop & (bad_acc | (new_len < MIN_LEN)));

    trunc_inc = {1'b0, force_term} + {1'b0, accept & over};

    next_state = state;
    if (accept) begin
      next_state = cap_eop ? ((over & ~ieop) ? S_DROP : S_IDLE) : S_PKT;
    end else if ((state == S_DROP) && ivalid && ieop) begin
      next_state = S_IDLE;
    end
  end

  // Framing state, hold register, registered outputs and statistics counters.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state      <= S_IDLE;
      hold_valid <= 1'b0;
      hold_sop   <= 1'b0;
      hold_eop   <= 1'b0;
      hold_res   <= 2'd0;
      hold_bad   <= 1'b0;
      hold_data  <= '0;
      len_q      <= 14'd0;
      bad_q      <= 1'b0;
      ovalid     <= 1'b0;
      osop       <= 1'b0;
      oeop       <= 1'b0;
      oresidual  <= 2'd0;
      odata      <= '0;
      obad       <= 1'b0;
      opkt_cnt   <= '0;
      orphan_cnt <= '0;
      trunc_cnt  <= '0;
    end else begin
      state     <= next_state;
      ovalid    <= emit;
      osop      <= emit & hold_sop;
      oeop      <= emit & (hold_eop | force_term);
      oresidual <= (emit & hold_eop) ? hold_res : 2'd0;
      odata     <= emit ? hold_data : '0;
      obad      <= emit & (force_term | (hold_eop & hold_bad));
      if (accept) begin
        hold_valid <= 1'b1;
        hold_sop   <= isop;
        hold_eop   <= cap_eop;
        hold_res   <= cap_res;
        hold_bad   <= cap_bad;
        hold_data  <= idata;
        len_q      <= new_len[13:0];
        bad_q      <= bad_acc;
      end else if (emit) begin
        hold_valid <= 1'b0;
      end
      opkt_cnt   <= sat_add(opkt_cnt, {1'b0, pkt_inc});
      orphan_cnt <= sat_add(orphan_cnt, {1'b0, orphan_inc});
      trunc_cnt  <= sat_add(trunc_cnt, trunc_inc);
    end
  end

endmodule

// File: tb/tb_packet_framing_checker.sv
// Testbench for packet_framing_checker: two instances (default limits and a 64-byte
// maximum) share one input stream; a packet-level model predicts every output cycle.
module tb_packet_framing_checker;

  typedef struct packed {
    logic        v;
    logic        s;
    logic        e;
    logic [1:0]  r;
    logic        b;
    logic [31:0] d;
  } word_t;

  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic        drv_valid = 1'b0;
  logic        drv_sop = 1'b0;
  logic        drv_eop = 1'b0;
  logic [1:0]  drv_res = 2'd0;
  logic [31:0] drv_data = 32'd0;
  logic        drv_bad = 1'b0;

  logic        ovalid_a, osop_a, oeop_a, obad_a;
  logic [1:0]  ores_a;
  logic [31:0] odata_a;
  logic [15:0] opkt_a, orph_a, trunc_a;
  logic        ovalid_b, osop_b, oeop_b, obad_b;
  logic [1:0]  ores_b;
  logic [31:0] odata_b;
  logic [15:0] opkt_b, orph_b, trunc_b;

  int assertions = 0;
  int failures   = 0;
  bit run_cmp    = 1'b0;

  // Model state, index 0 = default instance, 1 = 64-byte maximum instance.
  int    maxb[2] = '{9600, 64};
  bit    in_pkt[2] = '{0, 0};
  bit    discard[2] = '{0, 0};
  int    bytes[2] = '{0, 0};
  bit    taint[2] = '{0, 0};
  bit    pend_v[2] = '{0, 0};
  word_t pend[2];
  word_t exp_w[2];
  int    exp_pkt[2] = '{0, 0};
  int    exp_orph[2] = '{0, 0};
  int    exp_trunc[2] = '{0, 0};

  // Observed statistics used by the hand-computed checks.
  int words[2] = '{0, 0};
  int sops[2] = '{0, 0};
  int eops[2] = '{0, 0};
  int badeops[2] = '{0, 0};
  int last_res[2] = '{0, 0};
  int last_bad[2] = '{0, 0};

  word_t act_w;
  int    act_pkt, act_orph, act_trunc;
  int    w0, w1, s0, e0, b0, b1;

  packet_framing_checker #(.DATA_WIDTH(32), .MIN_BYTES(64), .MAX_BYTES(9600), .CNT_WIDTH(16)) dut_a (
    .iclk(iclk), .irst(irst), .ivalid(drv_valid), .isop(drv_sop), .ieop(drv_eop),
    .iresidual(drv_res), .idata(drv_data), .ibad(drv_bad),
    .ovalid(ovalid_a), .osop(osop_a), .oeop(oeop_a), .oresidual(ores_a), .odata(odata_a),
    .obad(obad_a), .opkt_cnt(opkt_a), .orphan_cnt(orph_a), .trunc_cnt(trunc_a));

  packet_framing_checker #(.DATA_WIDTH(32), .MIN_BYTES(64), .MAX_BYTES(64), .CNT_WIDTH(16)) dut_b (
    .iclk(iclk), .irst(irst), .ivalid(drv_valid), .isop(drv_sop), .ieop(drv_eop),
    .iresidual(drv_res), .idata(drv_data), .ibad(drv_bad),
    .ovalid(ovalid_b), .osop(osop_b), .oeop(oeop_b), .oresidual(ores_b), .odata(odata_b),
    .obad(obad_b), .opkt_cnt(opkt_b), .orphan_cnt(orph_b), .trunc_cnt(trunc_b));

  always #5 iclk = ~iclk;

  function automatic int sat(input int x);
    return (x > 65535) ? 65535 : x;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    assertions++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock of the packet-level rules: release the pending word, then classify the input.
  task automatic modelStep(input int k);
    word_t w;
    word_t nw;
    exp_w[k] = '0;
    if (pend_v[k] && (drv_valid || pend[k].e)) begin
      w = pend[k];
      pend_v[k] = 1'b0;
      if (drv_valid && drv_sop && !w.e) begin
        w.e = 1'b1;
        w.r = 2'd0;
        w.b = 1'b1;
        exp_trunc[k] = sat(exp_trunc[k] + 1);
      end
      w.v = 1'b1;
      if (!w.e) w.b = 1'b0;
      exp_w[k] = w;
      if (w.e) exp_pkt[k] = sat(exp_pkt[k] + 1);
    end
    if (drv_valid) begin
      if (drv_sop) begin
        in_pkt[k] = 1'b1;
        discard[k] = 1'b0;
        bytes[k] = 0;
        taint[k] = 1'b0;
      end
      if (in_pkt[k]) begin
        taint[k] = taint[k] | drv_bad;
        nw = '0;
        nw.s = drv_sop;
        nw.d = drv_data;
        if (drv_eop) begin
          bytes[k] += (drv_res == 2'd0) ? 4 : int'(drv_res);
          nw.e = 1'b1;
          if (bytes[k] > maxb[k]) begin
            nw.b = 1'b1;
            exp_trunc[k] = sat(exp_trunc[k] + 1);
          end else begin
            nw.r = drv_res;
            nw.b = taint[k] || (bytes[k] < 64);
          end
          in_pkt[k] = 1'b0;
        end else begin
          bytes[k] += 4;
          if (bytes[k] >= maxb[k]) begin
            nw.e = 1'b1;
            nw.b = 1'b1;
            exp_trunc[k] = sat(exp_trunc[k] + 1);
            in_pkt[k] = 1'b0;
            discard[k] = 1'b1;
          end
        end
        pend[k] = nw;
        pend_v[k] = 1'b1;
      end else if (discard[k]) begin
        if (drv_eop) discard[k] = 1'b0;
      end else begin
        exp_orph[k] = sat(exp_orph[k] + 1);
      end
    end
  endtask

  // Advance the model on every clock; reset clears it just like the design.
  always @(posedge iclk or posedge irst) begin
    if (irst) begin
      for (int k = 0; k < 2; k++) begin
        in_pkt[k] = 1'b0; discard[k] = 1'b0; bytes[k] = 0; taint[k] = 1'b0;
        pend_v[k] = 1'b0; pend[k] = '0; exp_w[k] = '0;
        exp_pkt[k] = 0; exp_orph[k] = 0; exp_trunc[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) modelStep(k);
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge iclk) begin
    if (run_cmp) begin
      for (int k = 0; k < 2; k++) begin
        if (k == 0) begin
          act_w = {ovalid_a, osop_a, oeop_a, ores_a, obad_a, odata_a};
          act_pkt = int'(opkt_a); act_orph = int'(orph_a); act_trunc = int'(trunc_a);
        end else begin
          act_w = {ovalid_b, osop_b, oeop_b, ores_b, obad_b, odata_b};
          act_pkt = int'(opkt_b); act_orph = int'(orph_b); act_trunc = int'(trunc_b);
        end
        checkOutput((k == 0) ? "a_word" : "b_word", longint'(act_w), longint'(exp_w[k]));
        checkOutput((k == 0) ? "a_pkt_cnt" : "b_pkt_cnt", act_pkt, exp_pkt[k]);
        checkOutput((k == 0) ? "a_orphan_cnt" : "b_orphan_cnt", act_orph, exp_orph[k]);
        checkOutput((k == 0) ? "a_trunc_cnt" : "b_trunc_cnt", act_trunc, exp_trunc[k]);
        if (act_w.v) begin
          words[k]++;
          if (act_w.s) sops[k]++;
          if (act_w.e) begin
            eops[k]++;
            if (act_w.b) badeops[k]++;
            last_res[k] = int'(act_w.r);
            last_bad[k] = int'(act_w.b);
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic s, input logic e,
                               input logic [1:0] r, input logic [31:0] d, input logic b);
    @(negedge iclk);
    drv_valid = v; drv_sop = s; drv_eop = e; drv_res = r; drv_data = d; drv_bad = b;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
    #2;
  endtask

  task automatic sendPacket(input int n, input int lastres, input int badidx,
                            input bit with_eop, input logic [31:0] base);
    logic       last;
    logic [1:0] r;
    for (int i = 0; i < n; i++) begin
      last = with_eop && (i == n - 1);
      r = last ? 2'(lastres) : 2'd0;
      applyStimulus(1'b1, i == 0, last, r, base + 32'(i), i == badidx);
    end
  endtask

  initial begin
    @(posedge iclk);
    #1 run_cmp = 1'b1;
    idleCycles(2);
    checkOutput("rst_ovalid", ovalid_a, 0);
    checkOutput("rst_pkt_cnt", opkt_a, 0);
    checkOutput("rst_orphan_cnt", orph_a, 0);
    checkOutput("rst_trunc_cnt", trunc_a, 0);
    @(negedge iclk);
    #1 irst = 1'b0;

    // 64-byte packet passes clean
    w0 = words[0]; s0 = sops[0];
    sendPacket(16, 0, -1, 1'b1, 32'hA000_0000);
    idleCycles(3);
    checkOutput("t64_words", words[0] - w0, 16);
    checkOutput("t64_sops", sops[0] - s0, 1);
    checkOutput("t64_res", last_res[0], 0);
    checkOutput("t64_bad", last_bad[0], 0);
    checkOutput("t64_pkt_cnt", opkt_a, 1);

    // Residual handling and the minimum-length boundary
    sendPacket(16, 1, -1, 1'b1, 32'hB000_0000);
    idleCycles(3);
    checkOutput("t61_res", last_res[0], 1);
    checkOutput("t61_bad", last_bad[0], 1);
    sendPacket(17, 1, -1, 1'b1, 32'hB100_0000);
    idleCycles(3);
    checkOutput("t65_res", last_res[0], 1);
    checkOutput("t65_bad", last_bad[0], 0);
    checkOutput("t65_b_trunc", trunc_b, 1);
    sendPacket(15, 0, -1, 1'b1, 32'hB200_0000);
    idleCycles(3);
    checkOutput("t60_bad", last_bad[0], 1);
    checkOutput("t60_pkt_cnt", opkt_a, 4);

    // Missing eop: the fourth word is held until the next sop terminates it
    w0 = words[0]; b0 = badeops[0];
    sendPacket(4, 0, -1, 1'b0, 32'hC000_0000);
    idleCycles(3);
    checkOutput("stall_words", words[0] - w0, 3);
    sendPacket(20, 0, -1, 1'b1, 32'hC100_0000);
    idleCycles(3);
    checkOutput("miss_words", words[0] - w0, 24);
    checkOutput("miss_badeops", badeops[0] - b0, 1);
    checkOutput("miss_trunc", trunc_a, 1);
    checkOutput("miss_pkt_cnt", opkt_a, 6);
    checkOutput("miss_2nd_bad", last_bad[0], 0);

    // Over-length on the 64-byte instance
    w0 = words[0]; w1 = words[1]; e0 = eops[1];
    sendPacket(20, 0, -1, 1'b1, 32'hD000_0000);
    idleCycles(3);
    checkOutput("max_b_words", words[1] - w1, 16);
    checkOutput("max_b_eops", eops[1] - e0, 1);
    checkOutput("max_b_bad", last_bad[1], 1);
    checkOutput("max_b_res", last_res[1], 0);
    checkOutput("max_b_trunc", trunc_b, 4);
    checkOutput("max_a_words", words[0] - w0, 20);

    // Orphan words while idle, then a clean packet
    w0 = words[0];
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 32'hE000_0000 + 32'(i), 1'b0);
    idleCycles(2);
    checkOutput("orph_words", words[0] - w0, 0);
    checkOutput("orph_cnt_a", orph_a, 3);
    checkOutput("orph_cnt_b", orph_b, 3);
    sendPacket(16, 0, -1, 1'b1, 32'hE100_0000);
    idleCycles(3);
    checkOutput("orph_next_bad", last_bad[0], 0);

    // Back-to-back one-word packets
    w0 = words[0]; s0 = sops[0]; e0 = eops[0];
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 32'hF000_0000 + 32'(i), 1'b0);
    idleCycles(3);
    checkOutput("b2b_words", words[0] - w0, 8);
    checkOutput("b2b_sops", sops[0] - s0, 8);
    checkOutput("b2b_eops", eops[0] - e0, 8);

    // Upstream error on word 2 taints only the eop word
    b1 = badeops[0];
    sendPacket(20, 0, 1, 1'b1, 32'h1200_0000);
    idleCycles(3);
    checkOutput("ibad_bad", last_bad[0], 1);
    checkOutput("ibad_badeops", badeops[0] - b1, 1);
    checkOutput("ibad_pkt_cnt", opkt_a, 17);

    // Reset in the middle of a packet
    sendPacket(5, 0, -1, 1'b0, 32'h1300_0000);
    @(negedge iclk);
    #1 irst = 1'b1;
    drv_valid = 1'b0; drv_sop = 1'b0; drv_eop = 1'b0;
    @(negedge iclk);
    #2;
    checkOutput("mid_rst_ovalid", ovalid_a, 0);
    checkOutput("mid_rst_pkt_cnt", opkt_a, 0);
    checkOutput("mid_rst_trunc", trunc_a, 0);
    checkOutput("mid_rst_orphan", orph_a, 0);
    @(negedge iclk);
    #1 irst = 1'b0;
    idleCycles(2);
    sendPacket(16, 0, -1, 1'b1, 32'h1400_0000);
    idleCycles(3);
    checkOutput("post_rst_pkt_cnt", opkt_a, 1);
    checkOutput("post_rst_bad", last_bad[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
